command_encoder: RTL and testbench
==================================

# command_encoder

Serialises a decoded paint command (id, x, y) into the ASCII line format `MNEMONIC,XX,YY\n` consumed on the host/HID side. The output is one byte per handshake for a UART transmitter. It sits between the paint control logic and the UART TX byte interface, and is the transmit counterpart of the command decoder. Its output lines use the same mnemonics and digit layout, so the decoder parses every echoed line back to the same id and coordinates.

## Interface
Parameters: none.

- clk  in  1  system clock; all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  encoder can accept a command (registered)
- cmd_id  in  4  1 UP, 2 DOWN, 3 LEFT, 4 RIGHT, 5 ENTER, 6 COLOR, 7 PALETTE; others invalid
- x  in  7  first numeric field
- y  in  7  second numeric field
- tx_data  out  8  current ASCII byte
- tx_valid  out  1  tx_data valid
- tx_ready  in  1  UART TX accepts byte
- busy  out  1  frame in progress
- bad_cmd  out  1  one-cycle pulse: invalid id dropped

## Operation
- Accept on rising edge where cmd_valid && cmd_ready.
  - At acceptance, latch cmd_id and the clamped x and y.
  - Clamp rule: a value above 99 becomes 99.
  - Deassert cmd_ready.
- Invalid id (0, 8–15):
  - No bytes are emitted.
  - bad_cmd is high for exactly the following cycle.
  - cmd_ready returns high that same cycle.
- Valid id frame bytes, in this order:
  - mnemonic: "UP", "DOWN", "LEFT", "RIGHT", "ENTER", "COLOR" or "PALETTE" (2–7 bytes);
  - ",";
  - x tens digit, then x units digit, always two digits, zero padded;
  - ",";
  - y tens digit, then y units digit;
  - "\n" (0x0A).
- Frame length = mnemonic length + 7 (9 to 14 bytes).
- Digit conversion:
  - tens = value/10 and units = value − 10·tens, both computed at latch time.
  - Each digit is emitted as "0" + digit.
- States:
  - IDLE → MNEM: on accept of a valid id.
  - MNEM: a character index advances per transferred byte; → SEP1 after the last mnemonic character.
  - SEP1 → X1 → X0 → SEP2 → Y1 → Y0 → EOL: each step on a byte transfer.
  - EOL → IDLE: on the transfer of "\n".
- Byte transfer = tx_valid && tx_ready on a rising edge.
- busy is high in every state except IDLE.
- Input fields are ignored while busy; the latched copies are authoritative.

## Timing
- Reset values: cmd_ready 0, tx_valid 0, tx_data 0x00, busy 0, bad_cmd 0, state IDLE.
- cmd_ready rises on the first edge after rst deasserts.
- Accept at edge N → tx_valid=1 with the first mnemonic byte from edge N (visible in cycle N+1).
- With tx_ready held high:
  - one byte transfers per cycle;
  - the frame occupies exactly frame-length cycles.
- After "\n" transfers at edge M:
  - tx_valid=0 and cmd_ready=1 from edge M;
  - a new command can be accepted at edge M+1.
- Backpressure: while tx_valid && !tx_ready, tx_data and tx_valid hold unchanged.
- tx_valid never drops mid-frame.
- tx_valid and cmd_ready are never both high.
- rst asserted mid-frame:
  - all outputs return immediately to reset values;
  - the partial frame is abandoned, with no "\n" emitted.

## Test plan
- Reset release, then id=1, x=12, y=4, tx_ready=1.
  - Required bytes: "U","P",",","1","2",",","0","4","\n" on 9 consecutive cycles.
  - cmd_ready=1 the cycle after "\n".
- id=7, x=3, y=99, tx_ready toggling 1,0,0,1 repeatedly.
  - Required stream: "PALETTE,03,99\n" (14 bytes).
  - tx_data stable during every stall; no duplicated or dropped bytes.
- id=4, x=127, y=100.
  - Required stream: "RIGHT,99,99\n".
- id=0, then id=15.
  - Each: no tx_valid, a bad_cmd pulse of one cycle, cmd_ready high the next cycle.
- Two back-to-back commands (id=2 x=0 y=0; id=5 x=50 y=7) with cmd_valid held high.
  - Required: "DOWN,00,00\n" immediately followed by "ENTER,50,07\n".
  - Exactly one idle cycle between the "\n" and the "E".
- rst pulsed during the x-tens byte of an "LEFT" frame.
  - Required: outputs return to reset values in the reset cycle.
  - The next command after reset emits a complete fresh frame.

Source files
------------

// File: rtl/command_encoder.sv
// command_encoder: serialises (id, x, y) paint commands into ASCII lines
// "MNEMONIC,XX,YY\n", one byte per tx_valid/tx_ready handshake.
module command_encoder (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [3:0] cmd_id,
    input  logic [6:0] x,
    input  logic [6:0] y,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    input  logic       tx_ready,
    output logic       busy,
    output logic       bad_cmd,
    output logic [3:0] dbg_state
);

    // Handshakes: a command is taken on an edge where cmd_valid && cmd_ready;
    // a byte moves on an edge where tx_valid && tx_ready. Once tx_valid is
    // high, tx_data holds until that byte moves. cmd_ready is only high in IDLE.
    typedef enum logic [3:0] {
        S_IDLE, S_MNEM, S_SEP1, S_X1, S_X0, S_SEP2, S_Y1, S_Y0, S_EOL
    } state_t;

    state_t     r_state;
    state_t     w_next;
    logic [3:0] r_id;
    logic [2:0] r_idx;
    logic [3:0] r_x1, r_x0, r_y1, r_y0;
    logic       r_cmd_ready;
    logic       r_bad_cmd;

    logic       w_valid_id, w_accept, w_xfer;
    logic [6:0] w_x_cl, w_y_cl, w_x_t, w_y_t, w_x_u, w_y_u;
    logic [7:0] w_tx_data;

    function automatic logic [2:0] mnem_len(input logic [3:0] id);
        case (id)
            4'd1:    mnem_len = 3'd2;
            4'd2:    mnem_len = 3'd4;
            4'd3:    mnem_len = 3'd4;
            4'd7:    mnem_len = 3'd7;
            default: mnem_len = 3'd5;
        endcase
    endfunction

    // Mnemonics are left-aligned in a 7-character field; idx 0 is the first letter.
    function automatic logic [7:0] mnem_char(input logic [3:0] id, input logic [2:0] idx);
        logic [55:0] s;
        case (id)
            4'd1:    s = {"UP", 40'd0};
            4'd2:    s = {"DOWN", 24'd0};
            4'd3:    s = {"LEFT", 24'd0};
            4'd4:    s = {"RIGHT", 16'd0};
            4'd5:    s = {"ENTER", 16'd0};
            4'd6:    s = {"COLOR", 16'd0};
            default: s = "PALETTE";
        endcase
        mnem_char = s[55 - 8*int'(idx) -: 8];
    endfunction

    assign w_valid_id = (cmd_id >= 4'd1) && (cmd_id <= 4'd7);
    assign w_accept   = cmd_valid && r_cmd_ready;
    assign w_xfer     = tx_valid && tx_ready;

    assign w_x_cl = (x > 7'd99) ? 7'd99 : x;
    assign w_y_cl = (y > 7'd99) ? 7'd99 : y;
    assign w_x_t  = w_x_cl / 7'd10;
    assign w_y_t  = w_y_cl / 7'd10;
    assign w_x_u  = w_x_cl - w_x_t * 7'd10;
    assign w_y_u  = w_y_cl - w_y_t * 7'd10;

    always_comb begin
        w_next    = r_state;
        w_tx_data = 8'h00;
        case (r_state)
            S_IDLE: if (w_accept && w_valid_id) w_next = S_MNEM;
            S_MNEM: begin
                w_tx_data = mnem_char(r_id, r_idx);
                if (w_xfer && (r_idx == mnem_len(r_id) - 3'd1)) w_next = S_SEP1;
            end
            S_SEP1: begin
                w_tx_data = 8'h2C;
                if (w_xfer) w_next = S_X1;
            end
            S_X1: begin
                w_tx_data = {4'h3, r_x1};
                if (w_xfer) w_next = S_X0;
            end
            S_X0: begin
                w_tx_data = {4'h3, r_x0};
                if (w_xfer) w_next = S_SEP2;
            end
            S_SEP2: begin
                w_tx_data = 8'h2C;
                if (w_xfer) w_next = S_Y1;
            end
            S_Y1: begin
                w_tx_data = {4'h3, r_y1};
                if (w_xfer) w_next = S_Y0;
            end
            S_Y0: begin
                w_tx_data = {4'h3, r_y0};
                if (w_xfer) w_next = S_EOL;
            end
            S_EOL: begin
                w_tx_data = 8'h0A;
                if (w_xfer) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_id        <= 4'd0;
            r_idx       <= 3'd0;
            r_x1        <= 4'd0;
            r_x0        <= 4'd0;
            r_y1        <= 4'd0;
            r_y0        <= 4'd0;
            r_cmd_ready <= 1'b0;
            r_bad_cmd   <= 1'b0;
        end else begin
            r_state     <= w_next;
            r_cmd_ready <= (w_next == S_IDLE);
            r_bad_cmd   <= w_accept && !w_valid_id;
            if (w_accept && w_valid_id) begin
                r_id  <= cmd_id;
                r_idx <= 3'd0;
                r_x1  <= w_x_t[3:0];
                r_x0  <= w_x_u[3:0];
                r_y1  <= w_y_t[3:0];
                r_y0  <= w_y_u[3:0];
            end else if ((r_state == S_MNEM) && w_xfer) begin
                r_idx <= r_idx + 3'd1;
            end
        end
    end

    assign cmd_ready = r_cmd_ready;
    assign bad_cmd   = r_bad_cmd;
    assign tx_valid  = (r_state != S_IDLE);
    assign busy      = (r_state != S_IDLE);
    assign tx_data   = w_tx_data;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_command_encoder.sv
// Testbench for command_encoder: scoreboard of expected ASCII bytes built
// from a string model, drained against the DUT's byte handshake.
module tb_command_encoder;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [3:0] cmd_id = 4'd0;
    logic [6:0] x = 7'd0;
    logic [6:0] y = 7'd0;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready = 1'b1;
    logic       busy;
    logic       bad_cmd;
    logic [3:0] dbg_state;

    logic [7:0] exp_q[$];
    int n_checks = 0;
    int n_errors = 0;

    command_encoder dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_id(cmd_id), .x(x), .y(y), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(tx_ready), .busy(busy), .bad_cmd(bad_cmd), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    function automatic string mnem_name(input int id);
        case (id)
            1: return "UP";
            2: return "DOWN";
            3: return "LEFT";
            4: return "RIGHT";
            5: return "ENTER";
            6: return "COLOR";
            7: return "PALETTE";
            default: return "";
        endcase
    endfunction

    task automatic push_frame(input int id, input int xv, input int yv);
        string s;
        int cx, cy;
        cx = (xv > 99) ? 99 : xv;
        cy = (yv > 99) ? 99 : yv;
        s = $sformatf("%s,%02d,%02d\n", mnem_name(id), cx, cy);
        for (int i = 0; i < s.len(); i++) exp_q.push_back(s[i]);
    endtask

    // Offers a command and returns #1 after the edge that accepted it.
    task automatic send_cmd(input int id, input int xv, input int yv, input bit hold);
        int w;
        cmd_id = id[3:0];
        x = xv[6:0];
        y = yv[6:0];
        cmd_valid = 1'b1;
        w = 0;
        while (!cmd_ready && w < 50) begin
            @(posedge clk); #1;
            w++;
        end
        n_checks++;
        if (w >= 50) begin
            n_errors++;
            $display("FAIL accept_timeout: cmd_ready=%b required 1 within 50 cycles", cmd_ready);
            cmd_valid = 1'b0;
        end else begin
            if (id >= 1 && id <= 7) push_frame(id, xv, yv);
            @(posedge clk); #1;
            if (!hold) cmd_valid = 1'b0;
        end
    endtask

    // Drains the scoreboard; mode 0 = tx_ready high, mode 1 = pattern 1,0,0,1.
    task automatic drain(input int mode, input int stop_after, output int cycles);
        logic       pv, pr;
        logic [7:0] pd, e;
        bit         acc;
        int         n_xfer;
        n_xfer = 0;
        cycles = 0;
        while (exp_q.size() > 0 && n_xfer < stop_after && cycles < 400) begin
            tx_ready = (mode == 0) ? 1'b1 : ((cycles % 4 == 0) || (cycles % 4 == 3));
            pv = tx_valid;
            pd = tx_data;
            pr = tx_ready;
            acc = cmd_valid && cmd_ready;
            n_checks++;
            if (tx_valid && cmd_ready) begin
                n_errors++;
                $display("FAIL exclusive: tx_valid=%b cmd_ready=%b required not both 1", tx_valid, cmd_ready);
            end
            @(posedge clk); #1;
            cycles++;
            if (acc) cmd_valid = 1'b0;
            if (pv && pr) begin
                e = exp_q.pop_front();
                n_xfer++;
                n_checks++;
                if (pd !== e) begin
                    n_errors++;
                    $display("FAIL byte: got %h required %h", pd, e);
                end
                if (e != 8'h0A) begin
                    n_checks++;
                    if (tx_valid !== 1'b1) begin
                        n_errors++;
                        $display("FAIL valid_drop: tx_valid=%b required 1 mid-frame", tx_valid);
                    end
                end
            end else if (pv && !pr) begin
                n_checks++;
                if (tx_valid !== 1'b1 || tx_data !== pd) begin
                    n_errors++;
                    $display("FAIL stall_hold: tx_valid=%b tx_data=%h required 1 %h", tx_valid, tx_data, pd);
                end
            end
        end
        tx_ready = 1'b1;
        if (cycles >= 400) begin
            n_checks++;
            n_errors++;
            $display("FAIL drain_timeout: %0d bytes left required 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic check_idle_after(input string name);
        n_checks++;
        if (tx_valid !== 1'b0 || cmd_ready !== 1'b1 || busy !== 1'b0) begin
            n_errors++;
            $display("FAIL %s: tx_valid=%b cmd_ready=%b busy=%b required 0 1 0", name, tx_valid, cmd_ready, busy);
        end
    endtask

    task automatic test_reset();
        #2;
        n_checks++;
        if ({cmd_ready, tx_valid, busy, bad_cmd} !== 4'b0000 || tx_data !== 8'h00 || dbg_state !== 4'd0) begin
            n_errors++;
            $display("FAIL reset_vals: rdy=%b vld=%b busy=%b bad=%b data=%h st=%0d required 0 0 0 0 00 0",
                     cmd_ready, tx_valid, busy, bad_cmd, tx_data, dbg_state);
        end
        @(posedge clk); #3;
        rst = 1'b0;
        @(posedge clk); #1;
        n_checks++;
        if (cmd_ready !== 1'b1 || tx_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_release: cmd_ready=%b tx_valid=%b required 1 0", cmd_ready, tx_valid);
        end
    endtask

    task automatic test_basic();
        int c;
        send_cmd(1, 12, 4, 1'b0);
        n_checks++;
        if (tx_valid !== 1'b1 || tx_data !== "U") begin
            n_errors++;
            $display("FAIL first_byte: tx_valid=%b tx_data=%h required 1 55", tx_valid, tx_data);
        end
        drain(0, 1000, c);
        n_checks++;
        if (c != 9) begin
            n_errors++;
            $display("FAIL basic_len: %0d cycles required 9", c);
        end
        check_idle_after("basic_after_eol");
    endtask

    task automatic test_backpressure();
        int c;
        send_cmd(7, 3, 99, 1'b0);
        drain(1, 1000, c);
        n_checks++;
        if (c != 28) begin
            n_errors++;
            $display("FAIL bp_len: %0d cycles required 28", c);
        end
        check_idle_after("bp_after_eol");
    endtask

    task automatic test_clamp();
        int c;
        send_cmd(4, 127, 100, 1'b0);
        drain(0, 1000, c);
        n_checks++;
        if (c != 12) begin
            n_errors++;
            $display("FAIL clamp_len: %0d cycles required 12", c);
        end
    endtask

    task automatic test_bad_cmd(input int id);
        send_cmd(id, 5, 5, 1'b0);
        n_checks++;
        if (bad_cmd !== 1'b1 || tx_valid !== 1'b0 || cmd_ready !== 1'b1) begin
            n_errors++;
            $display("FAIL bad_pulse id=%0d: bad_cmd=%b tx_valid=%b cmd_ready=%b required 1 0 1",
                     id, bad_cmd, tx_valid, cmd_ready);
        end
        @(posedge clk); #1;
        n_checks++;
        if (bad_cmd !== 1'b0 || tx_valid !== 1'b0 || cmd_ready !== 1'b1) begin
            n_errors++;
            $display("FAIL bad_after id=%0d: bad_cmd=%b tx_valid=%b cmd_ready=%b required 0 0 1",
                     id, bad_cmd, tx_valid, cmd_ready);
        end
    endtask

    task automatic test_back_to_back();
        int c;
        send_cmd(2, 0, 0, 1'b1);
        push_frame(5, 50, 7);
        cmd_id = 4'd5;
        x = 7'd50;
        y = 7'd7;
        drain(0, 1000, c);
        n_checks++;
        if (c != 24) begin
            n_errors++;
            $display("FAIL b2b_len: %0d cycles required 24", c);
        end
        check_idle_after("b2b_after_eol");
    endtask

    task automatic test_mid_reset();
        int c;
        send_cmd(3, 34, 56, 1'b0);
        drain(0, 5, c);
        n_checks++;
        if (tx_data !== "3" || tx_valid !== 1'b1) begin
            n_errors++;
            $display("FAIL pre_reset: tx_data=%h tx_valid=%b required 33 1", tx_data, tx_valid);
        end
        rst = 1'b1;
        #1;
        n_checks++;
        if ({cmd_ready, tx_valid, busy, bad_cmd} !== 4'b0000 || tx_data !== 8'h00 || dbg_state !== 4'd0) begin
            n_errors++;
            $display("FAIL mid_reset: rdy=%b vld=%b busy=%b bad=%b data=%h st=%0d required 0 0 0 0 00 0",
                     cmd_ready, tx_valid, busy, bad_cmd, tx_data, dbg_state);
        end
        exp_q.delete();
        @(posedge clk); #2;
        rst = 1'b0;
        @(posedge clk); #1;
        n_checks++;
        if (cmd_ready !== 1'b1 || tx_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL post_reset: cmd_ready=%b tx_valid=%b required 1 0", cmd_ready, tx_valid);
        end
        send_cmd(3, 8, 91, 1'b0);
        drain(0, 1000, c);
        n_checks++;
        if (c != 11) begin
            n_errors++;
            $display("FAIL fresh_len: %0d cycles required 11", c);
        end
    endtask

    task automatic test_random();
        int c, id, xv, yv;
        for (int i = 0; i < 4; i++) begin
            id = $urandom_range(1, 7);
            xv = $urandom_range(0, 127);
            yv = $urandom_range(0, 127);
            send_cmd(id, xv, yv, 1'b0);
            drain(i % 2, 1000, c);
            check_idle_after("rand_after_eol");
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_clamp();
        test_bad_cmd(0);
        test_bad_cmd(15);
        test_back_to_back();
        test_mid_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
